// File: rtl/trace_arbiter.sv
// trace_arbiter: merges retirement and RF-write trace records into one cycle-stamped stream.
// The RF-write source is built only when TRACE_ARB_RF_PORT_EN is defined.
module trace_arbiter_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    assign empty = cnt == '0;
    assign full  = cnt == (AW+1)'(DEPTH);
    assign rdata = mem[rp];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                mem[wp] <= wdata;
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

module trace_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ret_valid_i,
    input  logic [31:0]       ret_pc_i,
    input  logic [31:0]       ret_insn_i,
    input  logic [4:0]        ret_rd_addr_i,
    input  logic [31:0]       ret_rd_wdata_i,
    input  logic              rf_wren_i,
    input  logic [4:0]        rf_rd_addr_i,
    input  logic [31:0]       rf_rd_wdata_i,
    output logic              trc_valid_o,
    input  logic              trc_ready_i,
    output logic              trc_src_o,
    output logic [31:0]       trc_cycle_o,
    output logic [31:0]       trc_pc_o,
    output logic [31:0]       trc_insn_o,
    output logic [31:0]       trc_wdata_o,
    output logic [4:0]        trc_rd_addr_o,
    output logic [DROP_W-1:0] drop_cnt_o
);
    typedef struct packed {
        logic        src;
        logic [31:0] cyc;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } rec_t;

    logic [31:0] cycle_q;
    logic [DROP_W-1:0] drop_q;
    logic prio_q;
    logic out_v;
    rec_t out_q, ret_rec, ret_head, rf_head;
    logic ret_empty, ret_full, ret_pop, ret_push, ret_drop;
    logic rf_empty, rf_pop, rf_drop;
    logic load, both, grant_rf;
    logic [1:0] drop_inc;
    logic [DROP_W:0] drop_sum;

    assign ret_rec = '{src: 1'b0, cyc: cycle_q, pc: ret_pc_i, insn: ret_insn_i,
                       wdata: ret_rd_wdata_i, rd: ret_rd_addr_i};
    assign load     = !out_v || trc_ready_i;
    assign both     = !ret_empty && !rf_empty;
    // prio_q names the winner of the next contested grant; uncontested grants leave it alone
    assign grant_rf = both ? prio_q : !rf_empty;
    assign ret_pop  = load && !ret_empty && !grant_rf;
    assign rf_pop   = load && !rf_empty && grant_rf;
    assign ret_push = ret_valid_i && (!ret_full || ret_pop);
    assign ret_drop = ret_valid_i && !ret_push;

    trace_arbiter_fifo #(.DEPTH(DEPTH), .W($bits(rec_t))) u_ret_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push(ret_push), .pop(ret_pop), .wdata(ret_rec),
        .rdata(ret_head), .empty(ret_empty), .full(ret_full)
    );

`ifdef TRACE_ARB_RF_PORT_EN
    rec_t rf_rec;
    logic rf_req, rf_push, rf_full;
    assign rf_rec  = '{src: 1'b1, cyc: cycle_q, pc: 32'd0, insn: 32'd0,
                       wdata: rf_rd_wdata_i, rd: rf_rd_addr_i};
    assign rf_req  = rf_wren_i && (rf_rd_addr_i != 5'd0);
    assign rf_push = rf_req && (!rf_full || rf_pop);
    assign rf_drop = rf_req && !rf_push;

    trace_arbiter_fifo #(.DEPTH(DEPTH), .W($bits(rec_t))) u_rf_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push(rf_push), .pop(rf_pop), .wdata(rf_rec),
        .rdata(rf_head), .empty(rf_empty), .full(rf_full)
    );
`else
    logic unused_rf;
    assign unused_rf = ^{rf_wren_i, rf_rd_addr_i, rf_rd_wdata_i};
    assign rf_empty  = 1'b1;
    assign rf_drop   = 1'b0;
    assign rf_head   = '0;
`endif

    assign drop_inc = {1'b0, ret_drop} + {1'b0, rf_drop};
    assign drop_sum = {1'b0, drop_q} + (DROP_W+1)'(drop_inc);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_q <= '0;
            drop_q  <= '0;
            prio_q  <= 1'b0;
            out_v   <= 1'b0;
            out_q   <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            drop_q  <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            if (load) out_v <= !ret_empty || !rf_empty;
            if (load && (!ret_empty || !rf_empty)) out_q <= grant_rf ? rf_head : ret_head;
            if (load && both) prio_q <= !prio_q;
        end
    end

    assign trc_valid_o   = out_v;
    assign trc_src_o     = out_q.src;
    assign trc_cycle_o   = out_q.cyc;
    assign trc_pc_o      = out_q.pc;
    assign trc_insn_o    = out_q.insn;
    assign trc_wdata_o   = out_q.wdata;
    assign trc_rd_addr_o = out_q.rd;
    assign drop_cnt_o    = drop_q;
endmodule

// File: tb/tb_trace_arbiter.sv
// tb_trace_arbiter: directed table, corner sequences and random traffic against a queue-based model.
module tb_trace_arbiter;
    localparam int DEPTH = 4;
`ifdef TRACE_ARB_RF_PORT_EN
    localparam bit RF_ON = 1'b1;
`else
    localparam bit RF_ON = 1'b0;
`endif

    logic clk_i = 0, rst_i = 1, ret_valid_i = 0, rf_wren_i = 0, trc_ready_i = 0;
    logic [31:0] ret_pc_i = 0, ret_insn_i = 0, ret_rd_wdata_i = 0, rf_rd_wdata_i = 0;
    logic [4:0] ret_rd_addr_i = 0, rf_rd_addr_i = 0;
    logic trc_valid_o, trc_src_o;
    logic [31:0] trc_cycle_o, trc_pc_o, trc_insn_o, trc_wdata_o;
    logic [4:0] trc_rd_addr_o;
    logic [15:0] drop_cnt_o;

    trace_arbiter #(.DEPTH(DEPTH), .DROP_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ret_valid_i(ret_valid_i), .ret_pc_i(ret_pc_i), .ret_insn_i(ret_insn_i),
        .ret_rd_addr_i(ret_rd_addr_i), .ret_rd_wdata_i(ret_rd_wdata_i),
        .rf_wren_i(rf_wren_i), .rf_rd_addr_i(rf_rd_addr_i), .rf_rd_wdata_i(rf_rd_wdata_i),
        .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i), .trc_src_o(trc_src_o),
        .trc_cycle_o(trc_cycle_o), .trc_pc_o(trc_pc_o), .trc_insn_o(trc_insn_o),
        .trc_wdata_o(trc_wdata_o), .trc_rd_addr_o(trc_rd_addr_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        src;
        logic [31:0] cyc, pc, insn, wdata;
        logic [4:0]  rd;
    } rec_t;

    rec_t ret_q[$], rf_q[$], m_out;
    logic m_v, m_prio;
    logic [31:0] m_cyc;
    int m_drop;

    task automatic model_reset();
        ret_q.delete();
        rf_q.delete();
        m_out = '{0, 0, 0, 0, 0, 0};
        m_v = 0;
        m_prio = 0;
        m_cyc = 0;
        m_drop = 0;
    endtask

    task automatic model_step();
        int drops = 0;
        rec_t r;
        if (!m_v || trc_ready_i) begin
            m_v = (ret_q.size() + rf_q.size()) > 0;
            if (ret_q.size() > 0 && rf_q.size() > 0) begin
                m_out = m_prio ? rf_q.pop_front() : ret_q.pop_front();
                m_prio = !m_prio;
            end else if (ret_q.size() > 0) m_out = ret_q.pop_front();
            else if (rf_q.size() > 0) m_out = rf_q.pop_front();
        end
        if (ret_valid_i) begin
            r = '{0, m_cyc, ret_pc_i, ret_insn_i, ret_rd_wdata_i, ret_rd_addr_i};
            if (ret_q.size() < DEPTH) ret_q.push_back(r);
            else drops++;
        end
        if (RF_ON && rf_wren_i && rf_rd_addr_i != 0) begin
            r = '{1, m_cyc, 0, 0, rf_rd_wdata_i, rf_rd_addr_i};
            if (rf_q.size() < DEPTH) rf_q.push_back(r);
            else drops++;
        end
        m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
        m_cyc = m_cyc + 1;
    endtask

    task automatic cycle_step();
        @(posedge clk_i);
        if (rst_i) model_reset();
        else model_step();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        ret_valid_i = 0;
        rf_wren_i = 0;
        rf_rd_addr_i = 0;
        trc_ready_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        cycle_step();
        rst_i = 0;
    endtask

    task automatic check_model();
        chk("model_valid", trc_valid_o, m_v);
        chk("model_drop", drop_cnt_o, m_drop);
        if (m_v) begin
            chk("model_src", trc_src_o, m_out.src);
            chk("model_cycle", trc_cycle_o, m_out.cyc);
            chk("model_pc", trc_pc_o, m_out.pc);
            chk("model_insn", trc_insn_o, m_out.insn);
            chk("model_wdata", trc_wdata_o, m_out.wdata);
            chk("model_rd", trc_rd_addr_o, m_out.rd);
        end
    endtask

    typedef struct {
        bit rv;
        logic [31:0] pc;
        bit rfw;
        logic [4:0] rfa;
        bit rdy;
        bit ev;
        logic [31:0] epc, ecyc;
        int edrop;
    } vec_t;

    vec_t tbl[10];
    logic [31:0] got[$];
    int highs;

    initial begin
        tbl[0] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 32'h80000000, 0, 0, 1, 0, 0, 0, 0};
        tbl[2] = '{0, 0, 1, 0, 1, 1, 32'h80000000, 1, 0};
        tbl[3] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[4] = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{0, 0, 0, 0, 0, 1, 32'h100, 4, 0};
        tbl[6] = '{1, 32'h104, 0, 0, 0, 1, 32'h100, 4, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 1, 32'h100, 4, 0};
        tbl[8] = '{0, 0, 0, 0, 1, 1, 32'h104, 6, 0};
        tbl[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

        model_reset();
        @(negedge clk_i);
        cycle_step();
        cycle_step();
        chk("rst_valid", trc_valid_o, 0);
        chk("rst_src", trc_src_o, 0);
        chk("rst_cycle", trc_cycle_o, 0);
        chk("rst_pc", trc_pc_o, 0);
        chk("rst_insn", trc_insn_o, 0);
        chk("rst_wdata", trc_wdata_o, 0);
        chk("rst_rd", trc_rd_addr_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        rst_i = 0;

        foreach (tbl[i]) begin
            ret_valid_i = tbl[i].rv;
            ret_pc_i = tbl[i].pc;
            ret_insn_i = 32'h13;
            rf_wren_i = tbl[i].rfw;
            rf_rd_addr_i = tbl[i].rfa;
            rf_rd_wdata_i = 32'hDEADBEEF;
            trc_ready_i = tbl[i].rdy;
            cycle_step();
            chk($sformatf("tbl%0d_valid", i), trc_valid_o, tbl[i].ev);
            chk($sformatf("tbl%0d_drop", i), drop_cnt_o, tbl[i].edrop);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_pc", i), trc_pc_o, tbl[i].epc);
                chk($sformatf("tbl%0d_cycle", i), trc_cycle_o, tbl[i].ecyc);
                chk($sformatf("tbl%0d_src", i), trc_src_o, 0);
            end
        end

        // round-robin alternation with both sources pushing every cycle
        do_reset();
        got.delete();
        for (int k = 0; k < 8; k++) begin
            ret_valid_i = 1;
            ret_pc_i = 32'h1000 + k * 4;
            rf_wren_i = 1;
            rf_rd_addr_i = 5;
            rf_rd_wdata_i = 32'hDEADBEEF;
            trc_ready_i = 1;
            cycle_step();
            if (trc_valid_o) begin
                got.push_back({31'd0, trc_src_o});
                if (trc_src_o) chk("alt_rf_wdata", trc_wdata_o, 32'hDEADBEEF);
                if (trc_src_o) chk("alt_rf_pc", trc_pc_o, 0);
            end
        end
        chk("alt_count", got.size() >= 4, 1);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk($sformatf("alt_src%0d", k), got[k], RF_ON ? k % 2 : 0);

        // stalled consumer: 4 FIFO + 1 output register survive, 5 dropped
        do_reset();
        for (int k = 0; k < 10; k++) begin
            ret_valid_i = 1;
            ret_pc_i = 32'h200 + k * 4;
            cycle_step();
        end
        ret_valid_i = 0;
        cycle_step();
        chk("stall_drop", drop_cnt_o, 5);
        got.delete();
        for (int k = 0; k < 20; k++) begin
            if (!trc_valid_o && got.size() > 0) break;
            if (trc_valid_o) got.push_back(trc_pc_o);
            trc_ready_i = 1;
            cycle_step();
        end
        chk("stall_count", got.size(), 5);
        for (int k = 0; k < 5 && k < got.size(); k++)
            chk($sformatf("stall_pc%0d", k), got[k], 32'h200 + k * 4);

        // mid-operation reset discards buffered and presented records
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ret_valid_i = 1;
            ret_pc_i = 32'h300 + k * 4;
            cycle_step();
        end
        ret_valid_i = 0;
        cycle_step();
        chk("mid_pre_valid", trc_valid_o, 1);
        rst_i = 1;
        ret_valid_i = 1;
        cycle_step();
        chk("mid_rst_valid", trc_valid_o, 0);
        chk("mid_rst_drop", drop_cnt_o, 0);
        chk("mid_rst_pc", trc_pc_o, 0);
        chk("mid_rst_cycle", trc_cycle_o, 0);
        rst_i = 0;
        ret_valid_i = 0;
        trc_ready_i = 1;
        highs = 0;
        for (int k = 0; k < 8; k++) begin
            cycle_step();
            if (trc_valid_o) highs++;
        end
        chk("mid_no_stale", highs, 0);

        // saturating drop counter: reach 0xFFFE, then two more drops
        do_reset();
        ret_valid_i = 1;
        for (int k = 0; k < 32'hFFFE + 5; k++) cycle_step();
        chk("sat_fffe", drop_cnt_o, 16'hFFFE);
        cycle_step();
        cycle_step();
        chk("sat_ffff", drop_cnt_o, 16'hFFFF);
        cycle_step();
        cycle_step();
        chk("sat_hold", drop_cnt_o, 16'hFFFF);

        // randomized traffic against the reference model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst_i = ($urandom_range(0, 199) == 0);
            ret_valid_i = ($urandom_range(0, 2) != 0);
            ret_pc_i = $urandom;
            ret_insn_i = $urandom;
            ret_rd_addr_i = 5'($urandom);
            ret_rd_wdata_i = $urandom;
            rf_wren_i = ($urandom_range(0, 1) != 0);
            rf_rd_addr_i = 5'($urandom_range(0, 7));
            rf_rd_wdata_i = $urandom;
            trc_ready_i = ((k / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cycle_step();
            check_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
